// File: rtl/pipe_pkg.sv
//------------------------------------------------------------------------------
// Module   : pipe_pkg
// Purpose  : Shared types and constants for the 5-stage MIPS pipeline.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package pipe_pkg;

  localparam int          INS_W    = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  // All-zero word decodes as sll $0,$0,0: a harmless write to $0.
  localparam logic [31:0] NOP_INS  = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DROP  = 2'd2
  } if_state_t;

  // Instruction plus its sequential successor address, as handed to decode.
  typedef struct packed {
    logic [INS_W-1:0] ins;
    logic [INS_W-1:0] npc;
  } fetch_bundle_t;

  // Sequential successor; wraps modulo 2^32, low bits passed through.
  function automatic logic [INS_W-1:0] next_pc(input logic [INS_W-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

`default_nettype wire

// File: rtl/if_stage_if.sv
//------------------------------------------------------------------------------
// Module   : if_stage_if
// Purpose  : Instruction-memory req/ack port between fetch and memory.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface if_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

`default_nettype wire

// File: rtl/if_skid_buf.sv
//------------------------------------------------------------------------------
// Module   : if_skid_buf
// Purpose  : Fetch output register pair plus a one-entry skid slot that parks
//            a word returned while decode is stalled.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module if_skid_buf
  import pipe_pkg::*;
#(
  parameter logic [31:0] NOP_INS = pipe_pkg::NOP_INS
) (
  input  wire           clk,
  input  wire           rst,        // asynchronous, active-low
  input  wire           load_out,   // in_data -> output regs, mark valid
  input  wire           park,       // in_data -> skid slot
  input  wire           unpark,     // skid slot -> output regs, mark valid
  input  wire           flush,      // outputs invalid/NOP, skid cleared
  input  fetch_bundle_t in_data,
  output fetch_bundle_t out_data,
  output logic          out_valid
);

  fetch_bundle_t out_q, out_d;
  fetch_bundle_t skid_q, skid_d;
  logic          valid_q, valid_d;

  // Next-state for output and skid registers; flush dominates everything.
  always_comb begin
    out_d   = out_q;
    skid_d  = skid_q;
    valid_d = valid_q;
    if (flush) begin
      out_d.ins = NOP_INS;
      valid_d   = 1'b0;
      skid_d    = '0;
    end else begin
      if (unpark) begin
        out_d   = skid_q;
        valid_d = 1'b1;
      end else if (load_out) begin
        out_d   = in_data;
        valid_d = 1'b1;
      end
      if (park) begin
        skid_d = in_data;
      end
    end
  end

  // State registers with asynchronous reset to an empty, invalid buffer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q.ins <= NOP_INS;
      out_q.npc <= '0;
      skid_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      out_q   <= out_d;
      skid_q  <= skid_d;
      valid_q <= valid_d;
    end
  end

  assign out_data  = out_q;
  assign out_valid = valid_q;

endmodule

`default_nettype wire

// File: rtl/if_stage.sv
//------------------------------------------------------------------------------
// Module   : if_stage
// Purpose  : Instruction-fetch stage: owns the PC, drives the instruction
//            memory req/ack port, absorbs decode stalls and applies redirects.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module if_stage #(
  parameter logic [31:0] RESET_PC = pipe_pkg::RESET_PC,
  parameter logic [31:0] NOP_INS  = pipe_pkg::NOP_INS
) (
  input  wire                clk,
  input  wire                rst,          // asynchronous, active-low
  if_stage_if.master         imem,
  input  wire                stall,
  input  wire                redirect,
  input  wire  [31:0]        redirect_pc,
  output logic [31:0]        ins,
  output logic [31:0]        npc_o,
  output logic               ins_valid
);

  import pipe_pkg::*;

  if_state_t     state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   redir_q, redir_d;
  logic [31:0]   pc_inc;
  logic          load_out, park, unpark, flush;
  fetch_bundle_t fetched;
  fetch_bundle_t out_data;

  assign pc_inc  = next_pc(pc_q);
  assign fetched = '{ins: imem.imem_rdata, npc: pc_inc};

  // Request stays up in FETCH/DROP so the address is stable until ack;
  // gated by reset so a pending fetch is abandoned immediately.
  assign imem.imem_req  = rst & (state_q != S_HOLD);
  assign imem.imem_addr = pc_q;

  // Fetch control: redirect > stall > normal flow.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    redir_d  = redir_q;
    load_out = 1'b0;
    park     = 1'b0;
    unpark   = 1'b0;
    flush    = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (redirect) begin
          flush = 1'b1;
          if (imem.imem_ack) begin
            pc_d = redirect_pc;
          end else begin
            // Keep the outstanding address stable; retarget after ack.
            redir_d = redirect_pc;
            state_d = S_DROP;
          end
        end else if (imem.imem_ack) begin
          pc_d = pc_inc;
          if (!ins_valid || !stall) begin
            load_out = 1'b1;
          end else begin
            park    = 1'b1;
            state_d = S_HOLD;
          end
        end else if (!stall) begin
          flush = 1'b1;  // bubble
        end
      end
      S_HOLD: begin
        if (redirect) begin
          flush   = 1'b1;
          pc_d    = redirect_pc;
          state_d = S_FETCH;
        end else if (!stall) begin
          unpark  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_DROP: begin
        flush = 1'b1;
        if (redirect) begin
          redir_d = redirect_pc;
        end
        if (imem.imem_ack) begin
          pc_d    = redirect ? redirect_pc : redir_q;
          state_d = S_FETCH;
        end
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // PC, state and pending-redirect registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      redir_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      redir_q <= redir_d;
    end
  end

  if_skid_buf #(
    .NOP_INS (NOP_INS)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .load_out  (load_out),
    .park      (park),
    .unpark    (unpark),
    .flush     (flush),
    .in_data   (fetched),
    .out_data  (out_data),
    .out_valid (ins_valid)
  );

  assign ins   = out_data.ins;
  assign npc_o = out_data.npc;

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
//------------------------------------------------------------------------------
// Module   : tb_if_stage
// Purpose  : Directed self-checking bench for if_stage.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] ins, npc_o;
  logic        ins_valid;

  logic        rst2 = 1'b0;
  logic        stall2 = 1'b0;
  logic        redirect2 = 1'b0;
  logic [31:0] redirect_pc2 = 32'h0;
  logic [31:0] ins2, npc2;
  logic        ins_valid2;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] lat = 32'd0;
  logic [31:0] lat_cnt = 32'd0;

  if_stage_if bus ();
  if_stage_if bus2 ();

  always #5 clk = ~clk;

  // Memory model: ack after 'lat' waiting cycles, data = address.
  assign bus.imem_ack   = bus.imem_req && (lat_cnt >= lat);
  assign bus.imem_rdata = bus.imem_ack ? bus.imem_addr : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (!bus.imem_req || bus.imem_ack) lat_cnt <= 32'd0;
    else                               lat_cnt <= lat_cnt + 32'd1;
  end

  // Zero-wait memory for the wrap instance.
  assign bus2.imem_ack   = bus2.imem_req;
  assign bus2.imem_rdata = bus2.imem_ack ? bus2.imem_addr : 32'hDEAD_BEEF;

  if_stage #(.RESET_PC(32'h0000_0000), .NOP_INS(32'h0000_0000)) u_dut (
    .clk(clk), .rst(rst), .imem(bus), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .ins(ins), .npc_o(npc_o), .ins_valid(ins_valid)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFC), .NOP_INS(32'h0000_0000)) u_dut_wrap (
    .clk(clk), .rst(rst2), .imem(bus2), .stall(stall2), .redirect(redirect2),
    .redirect_pc(redirect_pc2), .ins(ins2), .npc_o(npc2), .ins_valid(ins_valid2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    n_tests++;
    if (bus.imem_req !== 1'b0) begin
      n_fail++; $display("FAIL reset_req: got %b expected 0", bus.imem_req);
    end
    n_tests++;
    if (ins_valid !== 1'b0 || ins !== 32'h0 || npc_o !== 32'h0) begin
      n_fail++; $display("FAIL reset_out: got v=%b ins=%h npc=%h expected 0/0/0", ins_valid, ins, npc_o);
    end
    n_tests++;
    if (bus.imem_addr !== 32'h0) begin
      n_fail++; $display("FAIL reset_addr: got %h expected 0", bus.imem_addr);
    end
  endtask

  task automatic test_stream();
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (ins_valid !== 1'b1 || ins !== 32'(4*i) || npc_o !== 32'(4*i+4)) begin
        n_fail++;
        $display("FAIL stream_%0d: got v=%b ins=%h npc=%h expected 1/%h/%h",
                 i, ins_valid, ins, npc_o, 32'(4*i), 32'(4*i+4));
      end
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (ins !== 32'h8 || ins_valid !== 1'b1 || bus.imem_req !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold_%0d: got ins=%h v=%b req=%b expected 8/1/0",
                 i, ins, ins_valid, bus.imem_req);
      end
    end
    stall = 1'b0;
    tick();
    n_tests++;
    if (ins !== 32'hC || npc_o !== 32'h10 || ins_valid !== 1'b1) begin
      n_fail++; $display("FAIL stall_unpark: got ins=%h npc=%h v=%b expected c/10/1", ins, npc_o, ins_valid);
    end
    tick();
    n_tests++;
    if (ins !== 32'h10 || npc_o !== 32'h14 || ins_valid !== 1'b1) begin
      n_fail++; $display("FAIL stall_resume: got ins=%h npc=%h v=%b expected 10/14/1", ins, npc_o, ins_valid);
    end
  endtask

  task automatic test_redirect_same_cycle();
    redirect = 1'b1;
    redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    n_tests++;
    if (ins_valid !== 1'b0 || ins !== 32'h0 || bus.imem_addr !== 32'h100) begin
      n_fail++; $display("FAIL redir_flush: got v=%b ins=%h addr=%h expected 0/0/100", ins_valid, ins, bus.imem_addr);
    end
    tick();
    n_tests++;
    if (ins_valid !== 1'b1 || ins !== 32'h100 || npc_o !== 32'h104) begin
      n_fail++; $display("FAIL redir_target: got v=%b ins=%h npc=%h expected 1/100/104", ins_valid, ins, npc_o);
    end
  endtask

  task automatic test_redirect_pending();
    lat = 32'd3;
    redirect = 1'b1;
    redirect_pc = 32'h200;
    tick();
    n_tests++;
    if (ins_valid !== 1'b0 || bus.imem_addr !== 32'h104 || bus.imem_req !== 1'b1) begin
      n_fail++; $display("FAIL drop_enter: got v=%b addr=%h req=%b expected 0/104/1", ins_valid, bus.imem_addr, bus.imem_req);
    end
    redirect_pc = 32'h300;
    tick();
    redirect = 1'b0;
    n_tests++;
    if (bus.imem_addr !== 32'h104 || bus.imem_req !== 1'b1) begin
      n_fail++; $display("FAIL drop_stable1: got addr=%h req=%b expected 104/1", bus.imem_addr, bus.imem_req);
    end
    tick();
    n_tests++;
    if (bus.imem_addr !== 32'h104 || bus.imem_ack !== 1'b1 || ins_valid !== 1'b0) begin
      n_fail++; $display("FAIL drop_stable2: got addr=%h ack=%b v=%b expected 104/1/0", bus.imem_addr, bus.imem_ack, ins_valid);
    end
    tick();
    n_tests++;
    if (bus.imem_addr !== 32'h300 || ins_valid !== 1'b0 || ins !== 32'h0) begin
      n_fail++; $display("FAIL drop_retarget: got addr=%h v=%b ins=%h expected 300/0/0", bus.imem_addr, ins_valid, ins);
    end
  endtask

  task automatic test_reset_in_drop();
    redirect = 1'b1;
    redirect_pc = 32'h400;
    tick();
    redirect = 1'b0;
    n_tests++;
    if (bus.imem_addr !== 32'h300 || bus.imem_req !== 1'b1) begin
      n_fail++; $display("FAIL rdrop_pending: got addr=%h req=%b expected 300/1", bus.imem_addr, bus.imem_req);
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if (bus.imem_req !== 1'b0 || ins_valid !== 1'b0 || ins !== 32'h0 || bus.imem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL rdrop_async: got req=%b v=%b ins=%h addr=%h expected 0/0/0/0",
               bus.imem_req, ins_valid, ins, bus.imem_addr);
    end
    tick();
    lat = 32'd0;
    rst = 1'b1;
    tick();
    n_tests++;
    if (ins_valid !== 1'b1 || ins !== 32'h0 || npc_o !== 32'h4) begin
      n_fail++; $display("FAIL rdrop_restart: got v=%b ins=%h npc=%h expected 1/0/4", ins_valid, ins, npc_o);
    end
  endtask

  task automatic test_reset_pc_wrap();
    tick();
    rst2 = 1'b1;
    tick();
    n_tests++;
    if (ins_valid2 !== 1'b1 || ins2 !== 32'hFFFF_FFFC || npc2 !== 32'h0 || bus2.imem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_first: got v=%b ins=%h npc=%h addr=%h expected 1/fffffffc/0/0",
               ins_valid2, ins2, npc2, bus2.imem_addr);
    end
    tick();
    n_tests++;
    if (ins2 !== 32'h0 || npc2 !== 32'h4) begin
      n_fail++; $display("FAIL wrap_second: got ins=%h npc=%h expected 0/4", ins2, npc2);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_same_cycle();
    test_redirect_pending();
    test_reset_in_drop();
    test_reset_pc_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time=%0t expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
